// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional macro BTB_BYPASS_EN forwards a same-index update into the same-cycle lookup.
module branch_target_buffer #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_pc,
    output logic        predicted_taken,
    output logic [31:0] predicted_target,
    output logic        btb_hit,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic        update_taken
);

    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int ENTRIES  = 1 << INDEX_BITS;

    // Encoding is non-monotonic: taken states are the ones with bit 1 set.
    typedef enum logic [1:0] {
        STRONG_NOT_TAKEN = 2'b00,
        WEAK_NOT_TAKEN   = 2'b01,
        STRONG_TAKEN     = 2'b10,
        WEAK_TAKEN       = 2'b11
    } ctr_t;

    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    ctr_t                r_ctr    [ENTRIES];

    logic [INDEX_BITS-1:0] w_f_idx, w_u_idx;
    logic [TAG_BITS-1:0]   w_f_tag, w_u_tag;
    logic                  w_u_hit;
    logic                  w_wr;
    logic                  w_nxt_valid;
    logic [TAG_BITS-1:0]   w_nxt_tag;
    logic [31:0]           w_nxt_target;
    ctr_t                  w_nxt_ctr;
    logic                  w_l_valid;
    logic [TAG_BITS-1:0]   w_l_tag;
    logic [31:0]           w_l_target;
    ctr_t                  w_l_ctr;
    logic                  w_unused_bits;

    assign w_f_idx       = fetch_pc[INDEX_BITS+1:2];
    assign w_f_tag       = fetch_pc[31:INDEX_BITS+2];
    assign w_u_idx       = update_pc[INDEX_BITS+1:2];
    assign w_u_tag       = update_pc[31:INDEX_BITS+2];
    assign w_unused_bits = ^{fetch_pc[1:0], update_pc[1:0]};
    assign w_u_hit       = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

    function automatic ctr_t ctr_inc(input ctr_t c);
        case (c)
            STRONG_NOT_TAKEN: ctr_inc = WEAK_NOT_TAKEN;
            WEAK_NOT_TAKEN:   ctr_inc = WEAK_TAKEN;
            WEAK_TAKEN:       ctr_inc = STRONG_TAKEN;
            default:          ctr_inc = STRONG_TAKEN;
        endcase
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        case (c)
            STRONG_TAKEN:   ctr_dec = WEAK_TAKEN;
            WEAK_TAKEN:     ctr_dec = WEAK_NOT_TAKEN;
            WEAK_NOT_TAKEN: ctr_dec = STRONG_NOT_TAKEN;
            default:        ctr_dec = STRONG_NOT_TAKEN;
        endcase
    endfunction

    // Post-update image of the entry at the update index; equals the old entry when nothing is written.
    always_comb begin
        w_wr         = 1'b0;
        w_nxt_valid  = r_valid[w_u_idx];
        w_nxt_tag    = r_tag[w_u_idx];
        w_nxt_target = r_target[w_u_idx];
        w_nxt_ctr    = r_ctr[w_u_idx];
        if (update_en) begin
            if (w_u_hit) begin
                w_wr = 1'b1;
                if (update_taken) begin
                    w_nxt_ctr    = ctr_inc(r_ctr[w_u_idx]);
                    w_nxt_target = update_target;
                end else begin
                    w_nxt_ctr = ctr_dec(r_ctr[w_u_idx]);
                end
            end else if (update_taken) begin
                w_wr         = 1'b1;
                w_nxt_valid  = 1'b1;
                w_nxt_tag    = w_u_tag;
                w_nxt_target = update_target;
                w_nxt_ctr    = WEAK_TAKEN;
            end
        end
    end

    always_comb begin
        w_l_valid  = r_valid[w_f_idx];
        w_l_tag    = r_tag[w_f_idx];
        w_l_target = r_target[w_f_idx];
        w_l_ctr    = r_ctr[w_f_idx];
`ifdef BTB_BYPASS_EN
        if (rst_n && update_en && (w_u_idx == w_f_idx)) begin
            w_l_valid  = w_nxt_valid;
            w_l_tag    = w_nxt_tag;
            w_l_target = w_nxt_target;
            w_l_ctr    = w_nxt_ctr;
        end
`endif
    end

    assign btb_hit          = w_l_valid && (w_l_tag == w_f_tag);
    assign predicted_taken  = btb_hit && w_l_ctr[1];
    assign predicted_target = btb_hit ? w_l_target : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'h0;
                r_ctr[i]    <= STRONG_NOT_TAKEN;
            end
        end else if (w_wr) begin
            r_valid[w_u_idx]  <= w_nxt_valid;
            r_tag[w_u_idx]    <= w_nxt_tag;
            r_target[w_u_idx] <= w_nxt_target;
            r_ctr[w_u_idx]    <= w_nxt_ctr;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: vector table for update/lookup pairs,
// hand sequences for same-cycle update/lookup and reset-with-update.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        predicted_taken;
    logic [31:0] predicted_target;
    logic        btb_hit;
    logic        update_en;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_target_buffer #(.INDEX_BITS(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_pc         (fetch_pc),
        .predicted_taken  (predicted_taken),
        .predicted_target (predicted_target),
        .btb_hit          (btb_hit),
        .update_en        (update_en),
        .update_pc        (update_pc),
        .update_target    (update_target),
        .update_taken     (update_taken)
    );

    typedef struct {
        logic        u_en;
        logic [31:0] u_pc;
        logic [31:0] u_tgt;
        logic        u_tk;
        logic [31:0] f_pc;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_lookup(input string name, input logic eh, input logic et, input logic [31:0] etgt);
        chk({name, ".hit"}, {31'b0, btb_hit}, {31'b0, eh});
        chk({name, ".taken"}, {31'b0, predicted_taken}, {31'b0, et});
        chk({name, ".target"}, predicted_target, etgt);
    endtask

    initial begin
        // u_en, u_pc, u_tgt, u_tk, f_pc, exp hit, exp taken, exp target
        vecs[0]  = '{1'b0, 32'h0,   32'h0,   1'b0, 32'h40,  1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h40,  32'h100, 1'b1, 32'h40,  1'b1, 1'b1, 32'h100}; // alloc WT
        vecs[2]  = '{1'b1, 32'h40,  32'h999, 1'b0, 32'h40,  1'b1, 1'b0, 32'h100}; // WNT, target kept
        vecs[3]  = '{1'b1, 32'h40,  32'h0,   1'b0, 32'h40,  1'b1, 1'b0, 32'h100}; // SNT
        vecs[4]  = '{1'b1, 32'h40,  32'h0,   1'b0, 32'h40,  1'b1, 1'b0, 32'h100}; // SNT sat
        vecs[5]  = '{1'b1, 32'h40,  32'h104, 1'b1, 32'h40,  1'b1, 1'b0, 32'h104}; // WNT
        vecs[6]  = '{1'b1, 32'h40,  32'h108, 1'b1, 32'h40,  1'b1, 1'b1, 32'h108}; // WT
        vecs[7]  = '{1'b1, 32'h40,  32'h108, 1'b1, 32'h40,  1'b1, 1'b1, 32'h108}; // ST
        vecs[8]  = '{1'b1, 32'h40,  32'h108, 1'b1, 32'h40,  1'b1, 1'b1, 32'h108}; // ST sat
        vecs[9]  = '{1'b1, 32'h40,  32'h0,   1'b0, 32'h40,  1'b1, 1'b1, 32'h108}; // WT
        vecs[10] = '{1'b1, 32'h40,  32'h0,   1'b0, 32'h40,  1'b1, 1'b0, 32'h108}; // WNT
        vecs[11] = '{1'b1, 32'h440, 32'h200, 1'b1, 32'h40,  1'b0, 1'b0, 32'h0};   // alias evicts
        vecs[12] = '{1'b0, 32'h0,   32'h0,   1'b0, 32'h440, 1'b1, 1'b1, 32'h200};
        vecs[13] = '{1'b1, 32'h440, 32'h0,   1'b0, 32'h440, 1'b1, 1'b0, 32'h200}; // WT->WNT
        vecs[14] = '{1'b1, 32'h80,  32'h300, 1'b0, 32'h80,  1'b0, 1'b0, 32'h0};   // NT miss, no alloc
        vecs[15] = '{1'b1, 32'h84,  32'h400, 1'b1, 32'h84,  1'b1, 1'b1, 32'h400};
        vecs[16] = '{1'b0, 32'h0,   32'h0,   1'b0, 32'h86,  1'b1, 1'b1, 32'h400}; // pc[1:0] ignored
        vecs[17] = '{1'b0, 32'h0,   32'h0,   1'b0, 32'h440, 1'b1, 1'b0, 32'h200};
        vecs[18] = '{1'b1, 32'h40,  32'h0,   1'b0, 32'h440, 1'b1, 1'b0, 32'h200}; // NT alias miss: no change

        rst_n         = 1'b0;
        fetch_pc      = 32'h0;
        update_en     = 1'b0;
        update_pc     = 32'h0;
        update_target = 32'h0;
        update_taken  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fetch_pc = 32'h40;
        #1;
        chk_lookup("in_reset", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            update_en     = vecs[i].u_en;
            update_pc     = vecs[i].u_pc;
            update_target = vecs[i].u_tgt;
            update_taken  = vecs[i].u_tk;
            fetch_pc      = vecs[i].f_pc;
            @(posedge clk);
            #1;
            update_en = 1'b0;
            #1;
            chk_lookup($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_tk, vecs[i].e_tgt);
        end

        // Same-cycle allocate at 0x48 (fresh index 2) while fetching 0x48.
        @(negedge clk);
        fetch_pc      = 32'h48;
        update_en     = 1'b1;
        update_pc     = 32'h48;
        update_target = 32'h500;
        update_taken  = 1'b1;
        #1;
`ifdef BTB_BYPASS_EN
        chk_lookup("same_cycle", 1'b1, 1'b1, 32'h500);
`else
        chk_lookup("same_cycle", 1'b0, 1'b0, 32'h0);
`endif
        @(posedge clk);
        #1;
        update_en = 1'b0;
        #1;
        chk_lookup("next_cycle", 1'b1, 1'b1, 32'h500);

        // Reset together with a taken update to 0x4C: everything forgotten, update dropped.
        @(negedge clk);
        rst_n         = 1'b0;
        update_en     = 1'b1;
        update_pc     = 32'h4C;
        update_target = 32'h600;
        update_taken  = 1'b1;
        fetch_pc      = 32'h440;
        @(posedge clk);
        #1;
        update_en = 1'b0;
        #1;
        chk_lookup("rst_440", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        fetch_pc = 32'h84;
        #1;
        chk_lookup("rst_84", 1'b0, 1'b0, 32'h0);
        fetch_pc = 32'h48;
        #1;
        chk_lookup("rst_48", 1'b0, 1'b0, 32'h0);
        fetch_pc = 32'h4C;
        #1;
        chk_lookup("rst_4c", 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk_lookup("rst_4c_later", 1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
